// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked SR storage bits with complementary outputs.
// The S=R=1 combination is resolved by SR11_MODE and reported on a registered flag.
module sr_flip_flop #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               SR11_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qc,
    output logic [WIDTH-1:0] invalid
);

    // Out-of-range policy values fall back to hold.
    localparam int MODE = (SR11_MODE < 0 || SR11_MODE > 3) ? 0 : SR11_MODE;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] invalid_next;

    // Next state is pure bitwise logic rather than if/case on s and r, so an
    // unknown request propagates X into q instead of picking a branch.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        invalid_next = s & r;
        case (MODE)
            1:       q_next = (s & ~r) | (q & ~s & ~r) | (~q & s & r);
            2:       q_next = s | (q & ~r);
            3:       q_next = ~r & (s | q);
            default: q_next = (s & ~r) | (q & ~(s ^ r));
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: registered state uses non-blocking assignment so all flops sample the same pre-edge values.
            q       <= RESET_VAL;
            invalid <= '0;
        end else begin
            q       <= q_next;
            invalid <= invalid_next;
        end
    end

    assign qc = ~q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed self-checking bench: four WIDTH=1 instances (one per S=R=1 policy)
// share stimulus, and a WIDTH=4 instance with a non-zero reset value runs alongside.
module tb_sr_flip_flop;

    logic       clk;
    logic       rst_n;
    logic       s1, r1;
    logic [3:0] s4, r4;

    logic       q_m0, qc_m0, inv_m0;
    logic       q_m1, qc_m1, inv_m1;
    logic       q_m2, qc_m2, inv_m2;
    logic       q_m3, qc_m3, inv_m3;
    logic [3:0] q_w4, qc_w4, inv_w4;

    int checks   = 0;
    int failures = 0;

    sr_flip_flop #(.WIDTH(1), .SR11_MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m0), .qc(qc_m0), .invalid(inv_m0));
    sr_flip_flop #(.WIDTH(1), .SR11_MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m1), .qc(qc_m1), .invalid(inv_m1));
    sr_flip_flop #(.WIDTH(1), .SR11_MODE(2)) u_m2 (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m2), .qc(qc_m2), .invalid(inv_m2));
    sr_flip_flop #(.WIDTH(1), .SR11_MODE(3)) u_m3 (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(q_m3), .qc(qc_m3), .invalid(inv_m3));
    sr_flip_flop #(.WIDTH(4), .RESET_VAL(4'b1010), .SR11_MODE(0)) u_w4 (
        .clk(clk), .rst_n(rst_n), .s(s4), .r(r4), .q(q_w4), .qc(qc_w4), .invalid(inv_w4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic s;
        logic r;
        logic q;
        logic inv;
    } vec_t;

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_m0(input string name, input logic exp_q, input logic exp_inv);
        check({name, " q"}, {3'b0, q_m0}, {3'b0, exp_q});
        check({name, " qc"}, {3'b0, qc_m0}, {3'b0, ~exp_q});
        check({name, " inv"}, {3'b0, inv_m0}, {3'b0, exp_inv});
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{s: 1'b0, r: 1'b0, q: 1'b0, inv: 1'b0};
        vecs[1] = '{s: 1'b0, r: 1'b1, q: 1'b0, inv: 1'b0};
        vecs[2] = '{s: 1'b1, r: 1'b0, q: 1'b1, inv: 1'b0};
        vecs[3] = '{s: 1'b1, r: 1'b1, q: 1'b1, inv: 1'b1};
        vecs[4] = '{s: 1'b0, r: 1'b0, q: 1'b1, inv: 1'b0};
        vecs[5] = '{s: 1'b0, r: 1'b1, q: 1'b0, inv: 1'b0};
        vecs[6] = '{s: 1'b0, r: 1'b0, q: 1'b0, inv: 1'b0};

        // Reset held with a set request pending: it must be ignored.
        rst_n = 1'b0;
        s1 = 1'b1; r1 = 1'b0;
        s4 = 4'b1111; r4 = 4'b0000;
        #2;
        check_m0("reset async", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_m0("reset held", 1'b0, 1'b0);
        end
        check("w4 reset q", q_w4, 4'b1010);
        check("w4 reset qc", qc_w4, 4'b0101);
        check("w4 reset inv", inv_w4, 4'b0000);

        // Release; first edge with s=r=0 keeps the reset value.
        rst_n = 1'b1;
        s1 = 1'b0; r1 = 1'b0;
        s4 = 4'b0000; r4 = 4'b0000;
        tick();
        check_m0("post release", 1'b0, 1'b0);
        check("w4 post release", q_w4, 4'b1010);

        // Mode 0 directed sequence.
        for (int i = 0; i < 7; i++) begin
            s1 = vecs[i].s;
            r1 = vecs[i].r;
            tick();
            check_m0($sformatf("seq[%0d]", i), vecs[i].q, vecs[i].inv);
        end

        // WIDTH=4 independent bits.
        s4 = 4'b0001; r4 = 4'b1000;
        tick();
        check("w4 set/clr q", q_w4, 4'b0011);
        check("w4 set/clr qc", qc_w4, 4'b1100);
        s4 = 4'b0100; r4 = 4'b0100;
        tick();
        check("w4 sr11 q", q_w4, 4'b0011);
        check("w4 sr11 inv", inv_w4, 4'b0100);
        s4 = 4'b0000; r4 = 4'b0000;
        tick();
        check("w4 inv clear", inv_w4, 4'b0000);

        // S=R=1 policies starting from q=1.
        s1 = 1'b1; r1 = 1'b0;
        tick();
        check("pre sr11 m1", {3'b0, q_m1}, 4'd1);
        s1 = 1'b1; r1 = 1'b1;
        tick();
        check("m0 sr11 #1", {3'b0, q_m0}, 4'd1);
        check("m1 sr11 #1", {3'b0, q_m1}, 4'd0);
        check("m2 sr11 #1", {3'b0, q_m2}, 4'd1);
        check("m3 sr11 #1", {3'b0, q_m3}, 4'd0);
        check("m1 qc #1", {3'b0, qc_m1}, 4'd1);
        check("inv #1", {inv_m0, inv_m1, inv_m2, inv_m3}, 4'b1111);
        tick();
        check("m0 sr11 #2", {3'b0, q_m0}, 4'd1);
        check("m1 sr11 #2", {3'b0, q_m1}, 4'd1);
        check("m2 sr11 #2", {3'b0, q_m2}, 4'd1);
        check("m3 sr11 #2", {3'b0, q_m3}, 4'd0);
        check("inv #2", {inv_m0, inv_m1, inv_m2, inv_m3}, 4'b1111);

        // Asynchronous reset between edges with set held.
        s1 = 1'b1; r1 = 1'b0;
        tick();
        check_m0("pre async", 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_m0("async mid-cycle", 1'b0, 1'b0);
        check("async w4", q_w4, 4'b1010);
        tick();
        check_m0("async edge", 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        check_m0("async release", 1'b0, 1'b0);
        tick();
        check_m0("first edge after", 1'b1, 1'b0);

        // Glitches between edges must not reach q.
        s1 = 1'b0; r1 = 1'b0;
        #1 r1 = 1'b1;
        #1 s1 = 1'b1;
        #1 begin s1 = 1'b0; r1 = 1'b0; end
        tick();
        check_m0("glitch", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
